// File: rtl/fb_pkg.sv
// ============================================================================
//  Module   : fb_pkg
//  Brief    : Shared types and defaults for the double-buffered framebuffer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package fb_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_ARMED = 2'd1,
        ST_DRAW  = 2'd2,
        ST_PEND  = 2'd3
    } fb_state_t;

    localparam int DEF_H_RES       = 640;
    localparam int DEF_V_RES       = 480;
    localparam int DEF_COLOR_W     = 4;
    localparam int DEF_CLEAR_COLOR = 0;

endpackage

`default_nettype wire

// File: rtl/fb_swap_ctrl_bank.sv
// ============================================================================
//  Module   : fb_bank
//  Brief    : Single-port synchronous pixel RAM, read-first, 1-cycle read.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fb_bank #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        r_rdata <= r_mem[addr];
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/fb_swap_ctrl.sv
// ============================================================================
//  Module   : fb_swap_ctrl
//  Brief    : Double-buffered framebuffer with vblank-synchronous bank swap.
//             Define FB_SWAP_CLEAR_EN to build the post-swap clear engine.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fb_swap_ctrl
    import fb_pkg::*;
#(
    parameter int                 H_RES       = DEF_H_RES,
    parameter int                 V_RES       = DEF_V_RES,
    parameter int                 COLOR_W     = DEF_COLOR_W,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = COLOR_W'(DEF_CLEAR_COLOR),
    localparam int                NPIX        = H_RES * V_RES,
    localparam int                ADDR_W      = $clog2(NPIX),
    localparam int                ROW_W       = $clog2(V_RES),
    localparam int                COL_W       = $clog2(H_RES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vggo,
    input  logic               halt,
    input  logic               vblank,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COLOR_W-1:0] wr_color,
    input  logic               rd_en,
    input  logic [ROW_W-1:0]   row,
    input  logic [COL_W-1:0]   col,
    output logic [COLOR_W-1:0] pix_color,
    output logic               pix_valid,
    output logic               ready,
    output logic               front_sel,
    output logic               clear_busy,
    output logic               swap_pulse,
    output logic               wr_drop
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W:0]   c_npix_ext  = (ADDR_W + 1)'(NPIX);
`ifdef FB_SWAP_CLEAR_EN
    localparam fb_state_t c_reset_state = ST_CLEAR;
`else
    localparam fb_state_t c_reset_state = ST_ARMED;
`endif

    fb_state_t          r_state, w_state_nxt;
    logic               r_front_sel, r_swap, r_wr_drop, w_swap;
    logic               r_vggo_d, r_halt_d, r_edge_ok;
    logic               w_vggo_edge, w_halt_edge, w_wr_ok;
    logic               w_clear_busy, w_clr_last, w_go_pend;
    logic [ADDR_W-1:0]  w_clr_addr;
    logic               r_rd_vld, r_rd_oob, r_rd_sel, r_pix_vld, r_pix_oob, r_pix_sel;
    logic [ADDR_W-1:0]  r_rd_addr, w_rd_lin;
    logic               w_rd_oob;
    logic [COLOR_W-1:0] w_bank_rdata [2];

    // Edges are qualified off for the first cycle out of reset.
    assign w_vggo_edge = r_edge_ok & vggo & ~r_vggo_d;
    assign w_halt_edge = r_edge_ok & halt & ~r_halt_d;
    assign w_wr_ok     = wr_en && (r_state == ST_DRAW) && ({1'b0, wr_addr} < c_npix_ext);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vggo_d  <= 1'b0;
            r_halt_d  <= 1'b0;
            r_edge_ok <= 1'b0;
        end else begin
            r_vggo_d  <= vggo;
            r_halt_d  <= halt;
            r_edge_ok <= 1'b1;
        end
    end

`ifdef FB_SWAP_CLEAR_EN
    logic              r_clr_busy, r_go_pend;
    logic [ADDR_W-1:0] r_clr_addr;

    assign w_clr_last   = r_clr_busy && (r_clr_addr == c_last_addr);
    assign w_clear_busy = r_clr_busy;
    assign w_clr_addr   = r_clr_addr;
    assign w_go_pend    = r_go_pend;

    // One idle cycle on entry to CLEAR keeps the bank that was just swapped
    // away free for a read still in flight, then NPIX write cycles follow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_busy <= 1'b0;
            r_clr_addr <= '0;
            r_go_pend  <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_busy <= !w_clr_last;
            r_clr_addr <= (r_clr_busy && !w_clr_last) ? r_clr_addr + ADDR_W'(1) : '0;
            r_go_pend  <= w_clr_last ? 1'b0 : (r_go_pend | w_vggo_edge);
        end else begin
            r_clr_busy <= 1'b0;
            r_clr_addr <= '0;
            r_go_pend  <= 1'b0;
        end
    end
`else
    assign w_clr_last   = 1'b0;
    assign w_clear_busy = 1'b0;
    assign w_clr_addr   = '0;
    assign w_go_pend    = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        case (r_state)
            ST_CLEAR: if (w_clr_last) w_state_nxt = (w_go_pend | w_vggo_edge) ? ST_DRAW : ST_ARMED;
            ST_ARMED: if (w_vggo_edge) w_state_nxt = ST_DRAW;
            ST_DRAW:  if (w_halt_edge) w_state_nxt = ST_PEND;
            ST_PEND: begin
                if (vblank) begin
                    w_swap      = 1'b1;
                    w_state_nxt = c_reset_state;
                end
            end
            default:  w_state_nxt = c_reset_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_reset_state;
            r_front_sel <= 1'b0;
            r_swap      <= 1'b0;
            r_wr_drop   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_swap  <= w_swap;
            if (w_swap) r_front_sel <= ~r_front_sel;
            if (wr_en && !w_wr_ok) r_wr_drop <= 1'b1;
        end
    end

    assign w_rd_oob = (32'(row) >= 32'(V_RES)) || (32'(col) >= 32'(H_RES));
    assign w_rd_lin = ADDR_W'(32'(row) * 32'(H_RES) + 32'(col));

    // Bank select travels with the read so a swap mid-flight keeps the old bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld  <= 1'b0;
            r_rd_oob  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_rd_addr <= '0;
            r_pix_vld <= 1'b0;
            r_pix_oob <= 1'b0;
            r_pix_sel <= 1'b0;
        end else begin
            r_rd_vld  <= rd_en;
            r_rd_oob  <= w_rd_oob;
            r_rd_sel  <= r_front_sel;
            r_rd_addr <= w_rd_oob ? '0 : w_rd_lin;
            r_pix_vld <= r_rd_vld;
            r_pix_oob <= r_rd_oob;
            r_pix_sel <= r_rd_sel;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic               w_we;
        logic [ADDR_W-1:0]  w_addr;
        logic [COLOR_W-1:0] w_wdata;

        assign w_we    = (w_wr_ok || w_clear_busy) && (r_front_sel != 1'(b));
        assign w_addr  = w_we ? (w_clear_busy ? w_clr_addr : wr_addr) : r_rd_addr;
        assign w_wdata = w_clear_busy ? CLEAR_COLOR : wr_color;

        fb_bank #(
            .DEPTH  (NPIX),
            .ADDR_W (ADDR_W),
            .DATA_W (COLOR_W)
        ) u_bank (
            .clk   (clk),
            .we    (w_we),
            .addr  (w_addr),
            .wdata (w_wdata),
            .rdata (w_bank_rdata[b])
        );
    end

    assign pix_color  = (r_pix_vld && !r_pix_oob) ? w_bank_rdata[r_pix_sel] : '0;
    assign pix_valid  = r_pix_vld;
    assign ready      = (r_state == ST_DRAW);
    assign front_sel  = r_front_sel;
    assign clear_busy = w_clear_busy;
    assign swap_pulse = r_swap;
    assign wr_drop    = r_wr_drop;

endmodule

`default_nettype wire
